// File: rtl/kamus_pkg.sv
// Shared types for the kamus core: operation/register encodings, memory widths
// and the LSU state and latched-request types.
package kamus_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LH  = 4'd1,
        OP_LW  = 4'd2,
        OP_LBU = 4'd3,
        OP_LHU = 4'd4,
        OP_SB  = 4'd5,
        OP_SH  = 4'd6,
        OP_SW  = 4'd7,
        OP_NOP = 4'd15
    } operation_e;

    typedef enum logic [4:0] {
        REG_ZERO = 5'd0,
        REG_RA   = 5'd1,
        REG_SP   = 5'd2,
        REG_T0   = 5'd5,
        REG_A0   = 5'd10,
        REG_A1   = 5'd11,
        REG_A5   = 5'd15
    } register_e;

    typedef enum logic [1:0] {
        MW_BYTE,
        MW_HALF,
        MW_WORD
    } mem_width_e;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_RESP
    } lsu_state_e;

    typedef struct packed {
        operation_e op;
        register_e  rd;
        logic [1:0] offset;
    } lsu_req_t;

    function automatic logic op_is_load(input operation_e op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic op_is_store(input operation_e op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic mem_width_e op_width(input operation_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return MW_BYTE;
            OP_LH, OP_LHU, OP_SH: return MW_HALF;
            default:              return MW_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input operation_e op, input logic [1:0] offset);
        case (op_width(op))
            MW_HALF: return offset[0];
            MW_WORD: return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/kamus_lsu_align.sv
// Load-path lane extraction: picks the addressed byte/half from the raw word and
// sign- or zero-extends it according to the load operation.
module kamus_lsu_align
    import kamus_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  operation_e       op,
    input  logic [1:0]       offset,
    input  logic [XLEN-1:0]  word,
    output logic [XLEN-1:0]  data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Half-word selection ignores offset[0] so misaligned halves read the containing half.
    assign byte_lane = word[{offset, 3'b000} +: 8];
    assign half_lane = word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        data = '0;
        case (op)
            OP_LB:   data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            OP_LBU:  data = {{(XLEN-8){1'b0}}, byte_lane};
            OP_LH:   data = {{(XLEN-16){half_lane[15]}}, half_lane};
            OP_LHU:  data = {{(XLEN-16){1'b0}}, half_lane};
            OP_LW:   data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/kamus_lsu.sv
// Single-outstanding load/store unit: IDLE -> REQ -> WAIT -> RESP with a WAIT timeout.
// Define KAMUS_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
module kamus_lsu
    import kamus_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  operation_e       req_op_i,
    input  logic [XLEN-1:0]  req_addr_i,
    input  logic [XLEN-1:0]  req_wdata_i,
    input  register_e        req_rd_i,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic [3:0]       dmem_be_o,
    output logic [XLEN-1:0]  dmem_addr_o,
    output logic [XLEN-1:0]  dmem_wdata_o,
    input  logic             dmem_gnt_i,
    input  logic             dmem_rvalid_i,
    input  logic [XLEN-1:0]  dmem_rdata_i,
    output logic             rsp_valid_o,
    output logic [XLEN-1:0]  rsp_rdata_o,
    output register_e        rsp_rd_o,
    output logic             rsp_err_o,
    output logic             busy_o
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    lsu_state_e        state_q, state_d;
    lsu_req_t          req_q;
    logic [XLEN-1:2]   waddr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic [CW-1:0]     cnt_q;
    logic              err_q, err_d;
    logic              bad_req;
    logic [XLEN-1:0]   load_data;
    logic [3:0]        be;
    logic              is_load;

    assign is_load = op_is_load(req_q.op);

`ifdef KAMUS_MISALIGN_TRAP_EN
    assign bad_req = !(is_load || op_is_store(req_q.op)) || is_misaligned(req_q.op, req_q.offset);
`else
    assign bad_req = !(is_load || op_is_store(req_q.op));
`endif

    kamus_lsu_align #(.XLEN(XLEN)) u_align (
        .op     (req_q.op),
        .offset (req_q.offset),
        .word   (rdata_q),
        .data   (load_data)
    );

    always_comb begin
        be = 4'b1111;
        case (op_width(req_q.op))
            MW_BYTE: be = 4'b0001 << req_q.offset;
            MW_HALF: be = 4'b0011 << {req_q.offset[1], 1'b0};
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LSU_IDLE;
            req_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= (state_q == LSU_WAIT) ? cnt_q + 1'b1 : '0;
            if (state_q == LSU_IDLE && req_valid_i) begin
                req_q.op     <= req_op_i;
                req_q.rd     <= req_rd_i;
                req_q.offset <= req_addr_i[1:0];
                waddr_q      <= req_addr_i[XLEN-1:2];
                wdata_q      <= req_wdata_i;
            end
            if (state_q == LSU_WAIT && dmem_rvalid_i) begin
                rdata_q <= dmem_rdata_i;
            end
        end
    end

    // Invalid or trapped requests still pass through REQ, but never raise dmem_req_o.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid_i) begin
                    state_d = LSU_REQ;
                    err_d   = 1'b0;
                end
            end
            LSU_REQ: begin
                if (bad_req) begin
                    state_d = LSU_RESP;
                    err_d   = 1'b1;
                end else if (dmem_gnt_i) begin
                    state_d = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (dmem_rvalid_i) begin
                    state_d = LSU_RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d = LSU_RESP;
                    err_d   = 1'b1;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = (state_q == LSU_IDLE);
        busy_o       = (state_q != LSU_IDLE);
        dmem_req_o   = (state_q == LSU_REQ) && !bad_req;
        dmem_we_o    = dmem_req_o && op_is_store(req_q.op);
        dmem_be_o    = dmem_req_o ? be : 4'b0000;
        dmem_addr_o  = {waddr_q, 2'b00};
        dmem_wdata_o = wdata_q;
        case (op_width(req_q.op))
            MW_BYTE: dmem_wdata_o = {(XLEN/8){wdata_q[7:0]}};
            MW_HALF: dmem_wdata_o = {(XLEN/16){wdata_q[15:0]}};
            default: dmem_wdata_o = wdata_q;
        endcase
        rsp_valid_o = (state_q == LSU_RESP);
        rsp_err_o   = rsp_valid_o && err_q;
        rsp_rdata_o = (rsp_valid_o && !err_q && is_load) ? load_data : '0;
        rsp_rd_o    = (rsp_valid_o && is_load) ? req_q.rd : REG_ZERO;
    end

endmodule

// File: tb/tb_kamus_lsu.sv
// Scoreboard bench for kamus_lsu: expected responses queued at issue, checked by a
// response monitor; per-scenario tasks check request fields and latency inline.
module tb_kamus_lsu;
    import kamus_pkg::*;

    localparam int XLEN = 32;
    localparam int TMO  = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              req_valid;
    logic              req_ready;
    operation_e        req_op;
    logic [XLEN-1:0]   req_addr, req_wdata;
    register_e         req_rd;
    logic              dmem_req, dmem_we;
    logic [3:0]        dmem_be;
    logic [XLEN-1:0]   dmem_addr, dmem_wdata;
    logic              dmem_gnt, dmem_rvalid;
    logic [XLEN-1:0]   dmem_rdata;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    register_e         rsp_rd;
    logic              rsp_err;
    logic              busy;

    kamus_lsu #(.XLEN(XLEN), .TIMEOUT_CYC(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rd_i(req_rd),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_be_o(dmem_be),
        .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
        .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_rd_o(rsp_rd),
        .rsp_err_o(rsp_err), .busy_o(busy)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
    } exp_t;
    exp_t sb[$];

    // Observations captured by drive_op
    logic        o_got, o_we, o_unstable, o_busy_low;
    int          o_lat, o_reqc;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_be;

    function automatic logic [31:0] model_load(input operation_e op, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
        case (op)
            OP_LB:   return b[7]  ? (b | 32'hFFFFFF00) : b;
            OP_LBU:  return b;
            OP_LH:   return h[15] ? (h | 32'hFFFF0000) : h;
            OP_LHU:  return h;
            OP_LW:   return w;
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL rsp_unexpected got rsp_valid=1 with empty scoreboard at %0t", $time);
            end else begin
                e = sb.pop_front();
                total++;
                if (rsp_rdata !== e.data) begin
                    bad++; $display("FAIL rsp_rdata got=%h exp=%h", rsp_rdata, e.data);
                end
                total++;
                if (5'(rsp_rd) !== e.rd) begin
                    bad++; $display("FAIL rsp_rd got=%0d exp=%0d", 5'(rsp_rd), e.rd);
                end
                total++;
                if (rsp_err !== e.err) begin
                    bad++; $display("FAIL rsp_err got=%b exp=%b", rsp_err, e.err);
                end
            end
        end
    end

    // Issues one operation and plays the memory side; rv_delay<0 means never respond.
    task automatic drive_op(input operation_e op, input logic [31:0] addr, input logic [31:0] wdata,
                            input register_e rd, input int gnt_delay, input int rv_delay,
                            input logic [31:0] word, input logic rv_in_gnt);
        int gnt_n;
        gnt_n = -1;
        o_got = 0; o_reqc = 0; o_unstable = 0; o_busy_low = 0; o_lat = -1;
        o_addr = '0; o_wdata = '0; o_be = '0; o_we = 0;
        @(negedge clk);
        req_valid = 1; req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
        @(posedge clk);
        #1 req_valid = 0;
        for (int n = 1; n <= TMO + 20 && !o_got; n++) begin
            @(negedge clk);
            dmem_gnt = 0; dmem_rvalid = 0;
            if (busy !== 1'b1) o_busy_low = 1;
            if (rsp_valid === 1'b1) begin
                o_got = 1; o_lat = n;
            end else begin
                if (dmem_req === 1'b1) begin
                    o_reqc++;
                    if (o_reqc == 1) begin
                        o_addr = dmem_addr; o_wdata = dmem_wdata; o_be = dmem_be; o_we = dmem_we;
                    end else if (dmem_addr !== o_addr || dmem_wdata !== o_wdata ||
                                 dmem_be !== o_be || dmem_we !== o_we) begin
                        o_unstable = 1;
                    end
                    if (o_reqc == gnt_delay + 1) begin
                        dmem_gnt = 1; gnt_n = n;
                        if (rv_in_gnt) begin dmem_rvalid = 1; dmem_rdata = ~word; end
                    end
                end
                if (gnt_n > 0 && rv_delay >= 0 && n == gnt_n + 1 + rv_delay) begin
                    dmem_rvalid = 1; dmem_rdata = word;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1; req_valid = 0; req_op = OP_LW; req_addr = '0; req_wdata = '0; req_rd = REG_ZERO;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if ({dmem_req, dmem_we, dmem_be} !== 6'b0) begin
            bad++; $display("FAIL reset_dmem_ctl got=%b exp=0", {dmem_req, dmem_we, dmem_be}); end
        total++; if (dmem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", dmem_addr); end
        total++; if ({rsp_valid, rsp_err} !== 2'b0) begin
            bad++; $display("FAIL reset_rsp_ctl got=%b exp=0", {rsp_valid, rsp_err}); end
        total++; if (rsp_rdata !== 32'h0 || 5'(rsp_rd) !== 5'd0) begin
            bad++; $display("FAIL reset_rsp_data got=%h/%0d exp=0/0", rsp_rdata, 5'(rsp_rd)); end
        rst = 0;
    endtask

    task automatic test_lw;
        sb.push_back('{32'hDEADBEEF, 5'(REG_A0), 1'b0});
        drive_op(OP_LW, 32'h100, 32'h0, REG_A0, 0, 0, 32'hDEADBEEF, 1'b0);
        total++; if (o_be !== 4'b1111 || o_addr !== 32'h100 || o_we !== 1'b0) begin
            bad++; $display("FAIL lw_req got be=%b addr=%h we=%b exp be=1111 addr=100 we=0", o_be, o_addr, o_we); end
        total++; if (o_lat !== 3) begin bad++; $display("FAIL lw_latency got=%0d exp=3", o_lat); end
    endtask

    task automatic test_lb_lbu;
        sb.push_back('{32'hFFFFFF80, 5'(REG_A1), 1'b0});
        drive_op(OP_LB, 32'h103, 32'h0, REG_A1, 0, 0, 32'h80FFFFFF, 1'b0);
        total++; if (o_be !== 4'b1000) begin bad++; $display("FAIL lb_be got=%b exp=1000", o_be); end
        sb.push_back('{32'h00000080, 5'(REG_A1), 1'b0});
        drive_op(OP_LBU, 32'h103, 32'h0, REG_A1, 0, 0, 32'h80FFFFFF, 1'b0);
        total++; if (o_got !== 1'b1) begin bad++; $display("FAIL lbu_done got=%b exp=1", o_got); end
    endtask

    task automatic test_sh;
        sb.push_back('{32'h0, 5'd0, 1'b0});
        drive_op(OP_SH, 32'h202, 32'h1234ABCD, REG_T0, 0, 0, 32'h0, 1'b0);
        total++; if (o_addr !== 32'h200) begin bad++; $display("FAIL sh_addr got=%h exp=200", o_addr); end
        total++; if (o_be !== 4'b1100) begin bad++; $display("FAIL sh_be got=%b exp=1100", o_be); end
        total++; if (o_wdata !== 32'hABCDABCD) begin bad++; $display("FAIL sh_wdata got=%h exp=abcdabcd", o_wdata); end
        total++; if (o_we !== 1'b1) begin bad++; $display("FAIL sh_we got=%b exp=1", o_we); end
    endtask

    task automatic test_gnt_stall;
        sb.push_back('{32'h0000BEEF, 5'(REG_SP), 1'b0});
        drive_op(OP_LHU, 32'h102, 32'h0, REG_SP, 5, 0, 32'hBEEF1234, 1'b1);
        total++; if (o_reqc !== 6) begin bad++; $display("FAIL stall_req_cycles got=%0d exp=6", o_reqc); end
        total++; if (o_unstable !== 1'b0) begin bad++; $display("FAIL stall_stable got=%b exp=0", o_unstable); end
        total++; if (o_busy_low !== 1'b0) begin bad++; $display("FAIL stall_busy_drop got=%b exp=0", o_busy_low); end
        total++; if (o_lat !== 8) begin bad++; $display("FAIL stall_latency got=%0d exp=8", o_lat); end
    endtask

    task automatic test_timeout;
        int pulses;
        sb.push_back('{32'h0, 5'(REG_A5), 1'b1});
        drive_op(OP_LW, 32'h300, 32'h0, REG_A5, 0, -1, 32'h0, 1'b0);
        total++; if (o_lat !== 2 + TMO) begin bad++; $display("FAIL timeout_latency got=%0d exp=%0d", o_lat, 2 + TMO); end
        pulses = 0;
        dmem_rvalid = 1; dmem_rdata = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dmem_rvalid = 0;
            if (rsp_valid === 1'b1) pulses++;
        end
        total++; if (pulses !== 0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL stray_rvalid got pulses=%0d ready=%b exp 0/1", pulses, req_ready); end
    endtask

    task automatic test_misalign;
`ifdef KAMUS_MISALIGN_TRAP_EN
        sb.push_back('{32'h0, 5'(REG_RA), 1'b1});
        drive_op(OP_LW, 32'h101, 32'h0, REG_RA, 0, 0, 32'hCAFEF00D, 1'b0);
        total++; if (o_reqc !== 0) begin bad++; $display("FAIL misalign_noreq got=%0d exp=0", o_reqc); end
        total++; if (o_lat !== 2) begin bad++; $display("FAIL misalign_latency got=%0d exp=2", o_lat); end
`else
        sb.push_back('{32'hCAFEF00D, 5'(REG_RA), 1'b0});
        drive_op(OP_LW, 32'h101, 32'h0, REG_RA, 0, 0, 32'hCAFEF00D, 1'b0);
        total++; if (o_addr !== 32'h100 || o_be !== 4'b1111) begin
            bad++; $display("FAIL misalign_issue got addr=%h be=%b exp 100/1111", o_addr, o_be); end
        total++; if (o_lat !== 3) begin bad++; $display("FAIL misalign_latency got=%0d exp=3", o_lat); end
`endif
    endtask

    task automatic test_bad_op;
        sb.push_back('{32'h0, 5'd0, 1'b1});
        drive_op(OP_NOP, 32'h400, 32'h0, REG_A0, 0, 0, 32'h0, 1'b0);
        total++; if (o_reqc !== 0) begin bad++; $display("FAIL badop_noreq got=%0d exp=0", o_reqc); end
        total++; if (o_lat !== 2) begin bad++; $display("FAIL badop_latency got=%0d exp=2", o_lat); end
    endtask

    task automatic test_reset_mid;
        int pulses;
        pulses = 0;
        @(negedge clk);
        req_valid = 1; req_op = OP_LW; req_addr = 32'h500; req_rd = REG_A0;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        dmem_gnt = 1;
        repeat (4) begin @(negedge clk); dmem_gnt = 0; end
        rst = 1;
        @(negedge clk);
        rst = 0;
        total++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_idle got ready=%b busy=%b exp 1/0", req_ready, busy); end
        dmem_rvalid = 1; dmem_rdata = 32'h55AA55AA;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dmem_rvalid = 0;
            if (rsp_valid === 1'b1) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL rstmid_no_rsp got=%0d exp=0", pulses); end
    endtask

    task automatic test_back_to_back;
        operation_e  ops[8]   = '{OP_LB, OP_LH, OP_LHU, OP_SB, OP_LBU, OP_SW, OP_LH, OP_SB};
        logic [31:0] addrs[8] = '{32'h10, 32'h22, 32'h30, 32'h43, 32'h51, 32'h60, 32'h70, 32'h81};
        for (int i = 0; i < 8; i++) begin
            int gd, rd_d;
            logic [31:0] w, wd, exp_wd;
            logic [3:0]  exp_be;
            gd = int'($urandom_range(0, 3)); rd_d = int'($urandom_range(0, 2));
            w = $urandom; wd = $urandom;
            if (op_is_store(ops[i])) sb.push_back('{32'h0, 5'd0, 1'b0});
            else sb.push_back('{model_load(ops[i], addrs[i][1:0], w), 5'(REG_A0), 1'b0});
            drive_op(ops[i], addrs[i], wd, REG_A0, gd, rd_d, w, 1'b0);
            total++; if (o_lat !== 3 + gd + rd_d) begin
                bad++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", i, o_lat, 3 + gd + rd_d); end
            if (ops[i] == OP_SB) begin
                exp_be = 4'b0001 << addrs[i][1:0];
                exp_wd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
                total++; if (o_be !== exp_be || o_wdata !== exp_wd) begin
                    bad++; $display("FAIL b2b_sb[%0d] got be=%b wdata=%h exp be=%b wdata=%h",
                                    i, o_be, o_wdata, exp_be, exp_wd); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_lw;
        test_lb_lbu;
        test_sh;
        test_gnt_stall;
        test_timeout;
        test_misalign;
        test_bad_op;
        test_reset_mid;
        test_back_to_back;
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sb_drain got=%0d pending exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/kamus_lsu.md
KAMUS_LSU -- requirements
Module: kamus_lsu

Interface
REQ-001 The block SHALL expose parameter XLEN, default 32, datapath and address width.
REQ-002 The block SHALL expose parameter TIMEOUT_CYC, default 255, the maximum number of cycles spent in WAIT before an error is reported.
REQ-003 The block SHALL have these ports, one per line:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- req_valid_i  in  1  EX presents a memory operation
- req_ready_o  out  1  LSU accepts it (IDLE only)
- req_op_i  in  operation_e  LB/LH/LW/LBU/LHU/SB/SH/SW
- req_addr_i  in  XLEN  byte address
- req_wdata_i  in  XLEN  store data, right-aligned
- req_rd_i  in  register_e  load destination
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  write enable
- dmem_be_o  out  4  byte enables
- dmem_addr_o  out  XLEN  word-aligned address
- dmem_wdata_o  out  XLEN  lane-shifted store data
- dmem_gnt_i  in  1  request granted
- dmem_rvalid_i  in  1  response or store acknowledge
- dmem_rdata_i  in  XLEN  raw read word
- rsp_valid_o  out  1  one-cycle completion pulse to WB
- rsp_rdata_o  out  XLEN  extended load data; 0 for stores
- rsp_rd_o  out  register_e  destination; zero for stores
- rsp_err_o  out  1  misaligned access or timeout
- busy_o  out  1  LSU not in IDLE; drives pipeline stall

Function
REQ-004 The FSM SHALL have states IDLE, REQ, WAIT and RESP.
REQ-005 IDLE: req_ready_o=1; on req_valid_i the op, address, data and rd SHALL be latched; the next state is REQ.
REQ-006 REQ: dmem_req_o=1 with registered address, be, we and wdata held stable until dmem_gnt_i; on grant the next state is WAIT.
REQ-007 WAIT: on dmem_rvalid_i, rdata SHALL be latched and the next state is RESP; rvalid in the grant cycle itself SHALL be ignored.
REQ-008 RESP: rsp_valid_o=1 for exactly one cycle; the next state is IDLE. Minimum accept-to-rsp_valid latency is 3 cycles.
REQ-009 Byte enables SHALL be: B 4'b0001<<addr[1:0]; H 4'b0011<<{addr[1],1'b0}; W 4'b1111.
REQ-010 dmem_addr_o SHALL be {addr[XLEN-1:2],2'b00}.
REQ-011 dmem_wdata_o SHALL replicate the byte or half into all lanes.
REQ-012 Load data SHALL be selected by addr[1:0]. LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, LW SHALL pass unchanged.
REQ-013 A WAIT counter SHALL increment each cycle. Reaching TIMEOUT_CYC SHALL force RESP with rsp_err_o=1 and rsp_rdata_o=0. A later stray dmem_rvalid_i in IDLE SHALL be ignored.
REQ-014 req_op_i outside the load/store set SHALL be accepted and completed in RESP with rsp_err_o=1, with no memory request.
REQ-015 busy_o SHALL equal (state != IDLE).

Reset
REQ-016 On rst_i the state SHALL be IDLE and the counter 0. dmem_req_o, dmem_we_o, dmem_be_o, rsp_valid_o and rsp_err_o SHALL be 0. rsp_rdata_o and dmem_addr_o SHALL be 0. rsp_rd_o SHALL be zero.
REQ-017 Reset mid-transaction SHALL abandon it with no response pulse; a subsequent dmem_rvalid_i SHALL be ignored.

Configuration
REQ-018 With KAMUS_MISALIGN_TRAP_EN defined, H with addr[0]=1 or W with addr[1:0]!=0 SHALL skip REQ/WAIT and go directly to RESP with rsp_err_o=1.
REQ-019 Without KAMUS_MISALIGN_TRAP_EN, misaligned accesses SHALL be issued with the offending low address bits forced to 0 and rsp_err_o=0.

Structure
REQ-020 The lsu_state_e enum and the lsu_req_t latched-request struct SHALL be added to kamus_pkg. operation_e, register_e and mem_width_e SHALL be reused from it.
REQ-021 The byte-lane extraction and extension logic SHALL be a combinational sub-module, kamus_lsu_align.

Verification
REQ-022 LW at 0x100, gnt immediate, rvalid next cycle with 0xDEADBEEF -> dmem_be_o=4'b1111, rsp_valid_o 3 cycles after accept, rsp_rdata_o=0xDEADBEEF.
REQ-023 LB at 0x103, rdata 0x80FFFFFF -> be=4'b1000, rsp_rdata_o=0xFFFFFF80. LBU at the same address -> 0x00000080.
REQ-024 SH at 0x202, wdata 0x1234ABCD -> dmem_addr_o=0x200, be=4'b1100, dmem_wdata_o=0xABCDABCD, rsp_rd_o=zero.
REQ-025 gnt withheld 5 cycles -> request fields stable, busy_o=1 throughout. No rvalid for TIMEOUT_CYC cycles -> rsp_err_o=1.
REQ-026 With the macro, LW at 0x101 -> no dmem_req_o, rsp_err_o=1 after 2 cycles. Without the macro -> dmem_addr_o=0x100, rsp_err_o=0.
REQ-027 rst_i asserted in WAIT, then rvalid -> rsp_valid_o stays 0, req_ready_o=1 the cycle after reset.
